down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
- Loadable synchronous down counter/timer: the count-down counterpart of the ripple up counters built from edge flip-flops.
- Loads a start value, counts to zero, pulses terminal count, then stops (one-shot) or reloads (periodic).
- Used as a tick/timeout generator beside the up counters; exposes true and complement count outputs, like the flip-flop q/qbar pair.

Parameters:
- WIDTH, 4, counter/data width in bits (1..16).
- PRESCALE, 4, cycles per decrement tick when DOWN_COUNTER_TIMER_PRESCALE_EN is defined (2..256); otherwise ignored.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- clear  in  1  reset, synchronous, active-low (clear=0 at a rising edge resets); priority over every other input.
- load  in  1  capture d into count and reload register.
- d  in  WIDTH  load value.
- start  in  1  begin or resume counting.
- stop  in  1  halt counting, hold count.
- auto_reload  in  1  1 = periodic mode, 0 = one-shot mode; sampled each tick.
- q  out  WIDTH  current count.
- qbar  out  WIDTH  always ~q, combinational from q.
- busy  out  1  1 while in RUN.
- done  out  1  1 while in DONE.
- tc  out  1  registered terminal-count pulse, exactly 1 cycle wide.

Behaviour:
- Reset (clear=0): state=IDLE, q=0, qbar=all ones, reload register=0, busy=0, done=0, tc=0, prescaler=0.
- State machine: IDLE, RUN, DONE. Registered outputs: busy=(state==RUN), done=(state==DONE).
- Input priority each edge: clear > load > stop > start > tick.
- IDLE:
  - load: q<=d, reload<=d.
  - start with next q!=0 (d if load is also high, else q): go to RUN.
  - start with next q==0: ignored, stay IDLE.
- RUN:
  - One tick per cycle by default.
  - On a tick: q>1 gives q<=q-1; q==1 gives q<=0 and tc=1 in the cycle q reads 0.
  - q==0 on a tick:
    - auto_reload=1 and reload!=0: q<=reload, stay RUN.
    - Otherwise: go to DONE, q holds 0.
  - Latency: d=3, load+start at edge 0 gives q=3,2,1,0 after edges 0,1,2,3; tc high only after edge 3.
  - Periodic period = reload+1 ticks.
  - load in RUN: q<=d, reload<=d, stay RUN, no tc; a load of 0 gives DONE on the next tick.
  - stop: go to IDLE, q holds; start later resumes from the held q.
  - stop and start together: stop wins.
- DONE:
  - start with reload!=0: q<=reload, go to RUN.
  - start with reload==0: ignored.
  - load: q<=d, reload<=d, go to IDLE.
  - stop: go to IDLE.
- tc never asserts in IDLE or DONE and is never high for two consecutive cycles.
- Arithmetic is unsigned; q never wraps below 0.
- Reset mid-RUN: next cycle matches the reset values above; tc dropped even if it was due.

Optional Feature:
- Macro: DOWN_COUNTER_TIMER_PRESCALE_EN.
- Defined: a prescaler counter (0..PRESCALE-1) runs only in RUN; a tick occurs when it wraps to 0, so one decrement per PRESCALE cycles.
  - Prescaler clears on clear, load, stop, and on every entry to RUN.
  - tc still lasts exactly 1 clk cycle.
  - Worked example: d=2, PRESCALE=4 gives q=2 for 4 cycles, q=1 for 4 cycles, then q=0 with tc.
- Undefined: no prescaler logic is generated; tick every cycle; PRESCALE unused.

Test Plan:
- Reset: hold clear=0 for 2 cycles mid-count -> q=0, qbar=4'hF, busy=0, done=0, tc=0.
- One-shot: d=3, load+start, auto_reload=0 -> q 3,2,1,0 on consecutive edges; tc one cycle at q=0; next edge done=1, busy=0; q stays 0 for 10 cycles.
- Periodic: d=2, auto_reload=1, run 12 cycles -> q sequence 2,1,0,2,1,0,...; tc every 3rd cycle; busy stays 1.
- Stop/resume: d=9, start; stop when q=5 -> IDLE, q holds 5 for 5 cycles; start -> 4,3,...,0, tc, DONE. stop+start in same cycle -> IDLE.
- Edges: start with q=0 in IDLE -> stays IDLE; load d=0 in RUN -> DONE on next tick, no tc; start in DONE with reload=6 -> q=6, RUN.
- Prescale build (PRESCALE=4): d=2 -> each count held 4 cycles; tc exactly 1 cycle; stop mid-prescale then start restarts a full 4-cycle interval.

Source files
------------

// File: rtl/down_counter_timer.sv
// Loadable down counter/timer with one-shot or periodic reload, terminal-count pulse and q/qbar outputs.
// Define DOWN_COUNTER_TIMER_PRESCALE_EN to decrement once every PRESCALE cycles instead of every cycle.
module down_counter_timer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             busy,
   output logic             done,
   output logic             tc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] reload, reload_nxt;
   logic             tc_nxt;
   logic             tick;

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pres;

   assign tick = (pres == PW'(PRESCALE - 1));

   // Prescaler only advances while staying in RUN, so every entry to RUN starts a full interval.
   always_ff @(posedge clk) begin
      if (!clear) begin
         pres <= '0;
      end else if (state != RUN || state_nxt != RUN || load || stop || tick) begin
         pres <= '0;
      end else begin
         pres <= pres + 1'b1;
      end
   end
`else
   // PRESCALE is always at least 1 here, so every cycle is a tick.
   assign tick = (PRESCALE > 0);
`endif

   always_comb begin
      state_nxt  = state;
      q_nxt      = q;
      reload_nxt = reload;
      tc_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               q_nxt      = d;
               reload_nxt = d;
            end
            if (!stop && start && q_nxt != '0) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (load) begin
               q_nxt      = d;
               reload_nxt = d;
            end else if (stop) begin
               state_nxt = IDLE;
            end else if (tick) begin
               if (q != '0) begin
                  q_nxt  = q - 1'b1;
                  tc_nxt = (q == WIDTH'(1));
               end else if (auto_reload && reload != '0) begin
                  q_nxt = reload;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (load) begin
               q_nxt      = d;
               reload_nxt = d;
               state_nxt  = IDLE;
            end else if (stop) begin
               state_nxt = IDLE;
            end else if (start && reload != '0) begin
               q_nxt     = reload;
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clear) begin
         state  <= IDLE;
         q      <= '0;
         reload <= '0;
         tc     <= 1'b0;
      end else begin
         state  <= state_nxt;
         q      <= q_nxt;
         reload <= reload_nxt;
         tc     <= tc_nxt;
      end
   end

   assign qbar = ~q;
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: rule-level model compared every cycle plus literal checkpoints.
module tb_down_counter_timer;

   localparam int W = 4;
`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   logic         clk = 1'b0;
   logic         clear = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] d = '0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         auto_reload = 1'b0;
   logic [W-1:0] q, qbar;
   logic         busy, done, tc;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   down_counter_timer #(.WIDTH(W), .PRESCALE(4)) dut (
      .clk(clk), .clear(clear), .load(load), .d(d), .start(start), .stop(stop),
      .auto_reload(auto_reload), .q(q), .qbar(qbar), .busy(busy), .done(done), .tc(tc)
   );

   always #5 clk = ~clk;

   // Model: mode 0 idle, 1 counting, 2 finished; pc counts cycles since the last tick.
   typedef struct {
      int mode;
      int q;
      int rel;
      int pc;
      bit tc;
   } mst_t;

   mst_t m;

   function automatic mst_t model_next(mst_t s, bit clr, bit ld, int dv, bit st, bit sp, bit ar);
      mst_t n;
      bit   tk;
      n    = s;
      n.tc = 1'b0;
      if (!clr) begin
         n.mode = 0; n.q = 0; n.rel = 0; n.pc = 0;
         return n;
      end
      tk = (s.mode == 1) && (s.pc == PS - 1);
      if (s.mode == 0) begin
         if (ld) begin n.q = dv; n.rel = dv; end
         if (!sp && st && n.q != 0) n.mode = 1;
      end else if (s.mode == 1) begin
         if (ld) begin n.q = dv; n.rel = dv; end
         else if (sp) n.mode = 0;
         else if (tk) begin
            if (s.q > 0) begin n.q = s.q - 1; n.tc = (n.q == 0); end
            else if (ar && s.rel != 0) n.q = s.rel;
            else n.mode = 2;
         end
      end else begin
         if (ld) begin n.q = dv; n.rel = dv; n.mode = 0; end
         else if (sp) n.mode = 0;
         else if (st && s.rel != 0) begin n.q = s.rel; n.mode = 1; end
      end
      n.pc = (s.mode == 1 && n.mode == 1 && !ld && !sp) ? (s.pc + 1) % PS : 0;
      return n;
   endfunction

   always @(posedge clk) begin
      m <= model_next(m, clear, load, int'(d), start, stop, auto_reload);
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_q",    int'(q),    m.q);
         check("model_qbar", int'(qbar), (~m.q) & ((1 << W) - 1));
         check("model_busy", int'(busy), int'(m.mode == 1));
         check("model_done", int'(done), int'(m.mode == 2));
         check("model_tc",   int'(tc),   int'(m.tc));
      end
   end

   task automatic cyc(input logic ld, input logic [W-1:0] dv, input logic st, input logic sp);
      load = ld; d = dv; start = st; stop = sp;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int tcs;
      idle(2);
      chk_en = 1'b1;
      check("reset_q", int'(q), 0);
      check("reset_qbar", int'(qbar), 15);
      check("reset_busy_done_tc", int'({busy, done, tc}), 0);
      clear = 1'b1;
`ifndef DOWN_COUNTER_TIMER_PRESCALE_EN
      // One-shot
      cyc(1'b1, 4'd3, 1'b1, 1'b0);
      check("os_q3", int'(q), 3);
      check("os_busy", int'(busy), 1);
      idle(2);
      check("os_q1", int'(q), 1);
      check("os_tc_lo", int'(tc), 0);
      idle(1);
      check("os_q0", int'(q), 0);
      check("os_tc", int'(tc), 1);
      idle(1);
      check("os_done", int'({busy, done, tc}), 3'b010);
      idle(10);
      check("os_hold", int'({q, done}), 1);
      // Periodic
      cyc(1'b1, 4'd2, 1'b0, 1'b0);
      auto_reload = 1'b1;
      cyc(1'b0, '0, 1'b1, 1'b0);
      tcs = 0;
      for (int i = 0; i < 12; i++) begin
         idle(1);
         tcs += int'(tc);
      end
      check("per_tc_count", tcs, 4);
      check("per_q", int'(q), 2);
      check("per_busy", int'(busy), 1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      auto_reload = 1'b0;
      // Stop / resume
      cyc(1'b1, 4'd9, 1'b1, 1'b0);
      idle(4);
      check("sr_q5", int'(q), 5);
      cyc(1'b0, '0, 1'b0, 1'b1);
      idle(5);
      check("sr_hold", int'({q, busy}), 10);
      cyc(1'b0, '0, 1'b1, 1'b0);
      idle(5);
      check("sr_tc", int'({q, tc}), 1);
      idle(1);
      check("sr_done", int'(done), 1);
      cyc(1'b1, 4'd7, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1);
      check("stop_start_idle", int'({q, busy, done}), 7 << 2);
      // Edge cases
      cyc(1'b1, 4'd0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("start_q0_idle", int'({busy, done}), 0);
      cyc(1'b1, 4'd5, 1'b1, 1'b0);
      cyc(1'b1, 4'd0, 1'b0, 1'b0);
      check("load0_run", int'({q, busy, tc}), 2);
      idle(1);
      check("load0_done", int'({done, tc}), 2);
      cyc(1'b1, 4'd6, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      idle(7);
      check("r6_done", int'(done), 1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("r6_restart", int'({q, busy}), 13);
      // Reset mid-run, including with tc due
      idle(2);
      clear = 1'b0;
      idle(2);
      check("mid_reset", int'({q, busy, done, tc}), 0);
      check("mid_reset_qbar", int'(qbar), 15);
      clear = 1'b1;
      cyc(1'b1, 4'd1, 1'b1, 1'b0);
      clear = 1'b0;
      idle(1);
      check("reset_drops_tc", int'({q, tc}), 0);
      clear = 1'b1;
      idle(2);
`else
      cyc(1'b1, 4'd2, 1'b1, 1'b0);
      idle(3);
      check("ps_q2_held", int'(q), 2);
      idle(1);
      check("ps_q1", int'(q), 1);
      idle(2);
      cyc(1'b0, '0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      idle(3);
      check("ps_restart_full", int'({q, tc}), 2);
      idle(1);
      check("ps_tc", int'({q, tc}), 1);
      idle(1);
      check("ps_tc_one", int'({tc, busy}), 1);
      idle(3);
      check("ps_done", int'(done), 1);
      clear = 1'b0;
      idle(2);
      check("ps_reset", int'({q, busy, done, tc}), 0);
      clear = 1'b1;
      idle(2);
`endif
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
